// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int unsigned BASE_ADDR_DEFAULT = 32'd1024;

  function automatic int unsigned beats_f(input int unsigned data_w, input int unsigned sram_w);
    return data_w / sram_w;
  endfunction

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned cnt_w_f(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Beat and wait-state counters for one multi-beat SRAM access.
module sram_beat_timer
  import arm_mem_pkg::*;
#(
  parameter int unsigned BEATS       = 2,
  parameter int unsigned WAIT_CYCLES = 1,
  localparam int unsigned BEAT_W     = cnt_w_f(BEATS),
  localparam int unsigned WAIT_W     = cnt_w_f(WAIT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              advance,
  output logic [BEAT_W-1:0] beat,
  output logic              last_cycle_of_beat,
  output logic              last_beat,
  output logic [BEAT_W-1:0] beat_nxt_c,
  output logic              last_cycle_nxt_c
);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  assign beat               = beat_q;
  assign last_cycle_of_beat = (wait_q == WAIT_W'(WAIT_CYCLES));
  assign last_beat          = (beat_q == BEAT_W'(BEATS - 1));
  assign beat_nxt_c         = beat_d;
  assign last_cycle_nxt_c   = (wait_d == WAIT_W'(WAIT_CYCLES));

  always_comb begin
    beat_d = beat_q;
    wait_d = wait_q;
    if (start) begin
      beat_d = '0;
      wait_d = '0;
    end else if (advance) begin
      if (last_cycle_of_beat) begin
        wait_d = '0;
        beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q <= '0;
      wait_q <= '0;
    end else begin
      beat_q <= beat_d;
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/arm_sram_mem_ctrl.sv
// MEM-stage controller: splits core loads/stores into narrow SRAM beats and freezes the pipeline meanwhile.
module arm_sram_mem_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SRAM_DATA_W = 16,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   freeze,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam int unsigned BEATS  = beats_f(DATA_W, SRAM_DATA_W);
  localparam int unsigned BEAT_W = cnt_w_f(BEATS);

  state_e                 state_q, state_d;
  logic                   op_wr_q, op_wr_d;
  logic [SRAM_ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rbuf_q, rbuf_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DATA_W-1:0] sram_dq_out_q, sram_dq_out_d;
  logic                   sram_dq_oe_q, sram_dq_oe_d;
  logic                   sram_we_n_q, sram_we_n_d;

  logic                   req_c, start_c, advance_c;
  logic [ADDR_W-1:0]      offset_c;
  logic [BEAT_W-1:0]      beat, beat_nxt_c;
  logic                   last_cycle_of_beat, last_beat, last_cycle_nxt_c;

  assign req_c     = mem_r_en | mem_w_en;
  assign start_c   = (state_q == IDLE) && req_c;
  assign advance_c = (state_q == ACCESS);
  assign offset_c  = address - ADDR_W'(BASE_ADDR);

  // Freeze must rise in the request cycle itself, so it is decoded from state and request.
  assign freeze      = advance_c || start_c;
  assign rdata       = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

  sram_beat_timer #(
    .BEATS       (BEATS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk                (clk),
    .rst                (rst),
    .start              (start_c),
    .advance            (advance_c),
    .beat               (beat),
    .last_cycle_of_beat (last_cycle_of_beat),
    .last_beat          (last_beat),
    .beat_nxt_c         (beat_nxt_c),
    .last_cycle_nxt_c   (last_cycle_nxt_c)
  );

  always_comb begin
    state_d       = state_q;
    op_wr_d       = op_wr_q;
    word_idx_d    = word_idx_q;
    wdata_d       = wdata_q;
    rbuf_d        = rbuf_q;
    rdata_d       = rdata_q;
    sram_addr_d   = '0;
    sram_dq_out_d = '0;
    sram_dq_oe_d  = 1'b0;
    sram_we_n_d   = 1'b1;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          state_d    = ACCESS;
          op_wr_d    = mem_w_en;
          word_idx_d = SRAM_ADDR_W'(offset_c >> 2);
          wdata_d    = wdata;
        end
      end
      ACCESS: begin
        if (!op_wr_q && last_cycle_of_beat) begin
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat == BEAT_W'(b)) rbuf_d[b*SRAM_DATA_W +: SRAM_DATA_W] = sram_dq_in;
          end
        end
        if (last_cycle_of_beat && last_beat) begin
          state_d = DONE;
          if (!op_wr_q) rdata_d = rbuf_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // SRAM pins are registered from next-cycle state so strobes are glitch-free.
    if (state_d == ACCESS) begin
      sram_addr_d = SRAM_ADDR_W'(word_idx_d * SRAM_ADDR_W'(BEATS)) + SRAM_ADDR_W'(beat_nxt_c);
      if (op_wr_d) begin
        sram_dq_oe_d = 1'b1;
        sram_we_n_d  = (WAIT_CYCLES != 0) && last_cycle_nxt_c;
        for (int unsigned b = 0; b < BEATS; b++) begin
          if (beat_nxt_c == BEAT_W'(b)) sram_dq_out_d = wdata_d[b*SRAM_DATA_W +: SRAM_DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      op_wr_q       <= 1'b0;
      word_idx_q    <= '0;
      wdata_q       <= '0;
      rbuf_q        <= '0;
      rdata_q       <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      op_wr_q       <= op_wr_d;
      word_idx_q    <= word_idx_d;
      wdata_q       <= wdata_d;
      rbuf_q        <= rbuf_d;
      rdata_q       <= rdata_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

endmodule

// File: doc/arm_sram_mem_ctrl.md
Name: arm_sram_mem_ctrl

Overview:
- Parametrised successor to the single-cycle data memory in the 5-stage ARM pipeline; sits in the MEM stage between the EX/MEM register outputs (MEM_R_EN, MEM_W_EN, ALU result as address, Val_Rm as write data) and an external asynchronous SRAM that is narrower than the core word.
- Splits each core word into BEATS SRAM accesses, each WAIT_CYCLES+1 cycles long.
- Raises a pipeline-wide freeze until the access completes, then returns the assembled read word to the MEM/WB register.

Parameters:
DATA_W, 32, core data word width
ADDR_W, 32, core address width
SRAM_DATA_W, 16, SRAM data bus width; must divide DATA_W; BEATS = DATA_W/SRAM_DATA_W
SRAM_ADDR_W, 18, SRAM word address width
WAIT_CYCLES, 1, extra cycles each beat is held (0 = one cycle per beat)
BASE_ADDR, 1024, core byte address mapped to SRAM word 0

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
mem_r_en  in  1  load request from EX/MEM register
mem_w_en  in  1  store request from EX/MEM register
address  in  ADDR_W  byte address (ALU result)
wdata  in  DATA_W  store data (Val_Rm)
rdata  out  DATA_W  load result to MEM/WB register
freeze  out  1  stall all pipeline registers and the PC
sram_addr  out  SRAM_ADDR_W  SRAM address
sram_dq_in  in  SRAM_DATA_W  SRAM read data
sram_dq_out  out  SRAM_DATA_W  SRAM write data
sram_dq_oe  out  1  top-level tristate enable for sram_dq_out
sram_we_n  out  1  SRAM write strobe, active low

Behaviour:
- Reset (rst=0, async, any state): state=IDLE; freeze=0; rdata=0; sram_we_n=1; sram_dq_oe=0; sram_addr=0; sram_dq_out=0; beat and wait counters=0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: freeze=0.
  - mem_r_en|mem_w_en=1: freeze=1 combinationally in the same cycle. Latch op, word index=(address-BASE_ADDR)>>2 and wdata. Go to ACCESS with beat=0, wait=0.
- ACCESS:
  - freeze=1.
  - sram_addr = word_index*BEATS + beat, truncated to SRAM_ADDR_W (modulo wrap, no error).
  - Write op: sram_dq_out = wdata slice [beat*SRAM_DATA_W +: SRAM_DATA_W]; sram_dq_oe=1; sram_we_n=0 for all cycles of the beat except the last, where sram_we_n=1 (address/data hold). When WAIT_CYCLES=0, sram_we_n=0 for the single cycle.
  - Read op: sram_dq_oe=0; sram_we_n=1; sram_dq_in is captured into the read assembly slice on the last cycle of each beat.
  - wait counts 0..WAIT_CYCLES, then beat increments. After the last cycle of beat BEATS-1, go to DONE.
  - Beat 0 is the least-significant slice (little-endian).
- DONE (exactly one cycle):
  - freeze=0, so the pipeline advances this cycle.
  - For a read, rdata updates to the assembled word at the entering edge and holds until the next read completes. Writes never change rdata.
  - Always go to IDLE; the request is not re-sampled in DONE.
- Latency per access: freeze high for 1 + BEATS*(WAIT_CYCLES+1) consecutive cycles, then DONE.
- Back-to-back requests: the next request is seen in IDLE the cycle after DONE. There are no idle SRAM cycles beyond that.
- Simultaneous mem_r_en and mem_w_en: write takes priority and rdata is unchanged (the decoder never issues this).
- Address and wdata inputs may change while frozen; the latched copies are used.
- Reset mid-ACCESS aborts the access. A partial write may leave the SRAM word half-updated; this is accepted.

Decomposition:
- Shared package arm_mem_pkg: state enum (IDLE/ACCESS/DONE), BEATS derivation, BASE_ADDR default constant.
- One sub-module, sram_beat_timer: owns the beat and wait counters, with outputs last_cycle_of_beat and last_beat. The controller FSM and datapath stay in arm_sram_mem_ctrl.

Test Plan:
- Defaults; store 0xDEADBEEF at 1024 → sram_addr 0 gets 0xBEEF, then 1 gets 0xDEAD, each held 2 cycles with sram_we_n low 1 cycle; freeze high 5 cycles, then low.
- Defaults; model SRAM word 2=0x5678, word 3=0x1234; load from 1028 → freeze 5 cycles; rdata=0x12345678 after DONE and stable through later stores.
- WAIT_CYCLES=0, SRAM_DATA_W=32; load → freeze exactly 2 cycles, sram_addr=word index, rdata correct.
- Two loads back-to-back (1032, then 1036) → each shows a 5-cycle freeze separated by DONE then IDLE; each rdata matches the model; no dropped or duplicated request.
- Assert rst=0 during beat 1 of a store → freeze, sram_we_n=1, sram_dq_oe=0 and rdata=0 immediately (async); after release, a new load completes normally.
- Request with both enables set → write performed, rdata unchanged.
